// File: rtl/instr_prefetch_if.sv
// Consumer-side handshake between the instruction prefetch queue and the control unit.
// The prefetch queue is the master; the control unit drives ready and redirect.
interface instr_prefetch_if #(
  parameter int PC_WIDTH = 6
);
  logic                instr_valid;
  logic                instr_ready;
  logic [15:0]         instr;
  logic [PC_WIDTH-1:0] instr_pc;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;

  modport master (
    output instr_valid, instr, instr_pc,
    input  instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  instr_valid, instr, instr_pc,
    output instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: walks sequential program addresses into a small FIFO,
// presents the head over valid/ready, flushes on redirect and stops at the halt address.
module instr_prefetch #(
  parameter int PC_WIDTH = 6,
  parameter int DEPTH    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   pm_addr,
  input  logic [15:0]           pm_data,
  instr_prefetch_if.master      cu,
  output logic                  halted,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PC_WIDTH-1:0] HALT_PC  = {PC_WIDTH{1'b1}};
  localparam logic [PTR_W:0]      FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]      ZERO_CNT = {(PTR_W+1){1'b0}};

  logic [PC_WIDTH-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [PTR_W-1:0]    wr_ptr_r, wr_ptr_nxt_s;
  logic [PTR_W-1:0]    rd_ptr_r, rd_ptr_nxt_s;
  logic [PTR_W:0]      count_r, count_nxt_s;
  logic                valid_r;
  logic                halted_r;
  logic                push_s;
  logic                pop_s;
  logic [15:0]         mem_instr_r [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc_r    [DEPTH];

  // A pop at full frees the slot the same cycle, so push may proceed alongside it.
  assign pop_s  = valid_r && cu.instr_ready && !cu.redirect;
  assign push_s = !cu.redirect && (fetch_pc_r != HALT_PC) &&
                  ((count_r != FULL_CNT) || pop_s);

  // Next-state for fetch address, pointers and occupancy; redirect overrides everything.
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    count_nxt_s    = count_r;
    if (cu.redirect) begin
      fetch_pc_nxt_s = cu.redirect_pc;
      wr_ptr_nxt_s   = {PTR_W{1'b0}};
      rd_ptr_nxt_s   = {PTR_W{1'b0}};
      count_nxt_s    = ZERO_CNT;
    end else begin
      if (push_s) begin
        fetch_pc_nxt_s = fetch_pc_r + PC_WIDTH'(1);
        wr_ptr_nxt_s   = wr_ptr_r + PTR_W'(1);
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
        wr_ptr_nxt_s   = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
        2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control state; valid and halted are registered from next-state so outputs never glitch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= {PC_WIDTH{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= ZERO_CNT;
      valid_r    <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      valid_r    <= (count_nxt_s != ZERO_CNT);
      halted_r   <= (fetch_pc_nxt_s == HALT_PC) && (count_nxt_s == ZERO_CNT);
    end
  end

  // Instruction storage is intentionally left uninitialised; valid gates its use.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_instr_r[wr_ptr_r] <= pm_data;
      mem_pc_r[wr_ptr_r]    <= fetch_pc_r;
    end
  end

  assign pm_addr        = fetch_pc_r;
  assign count          = count_r;
  assign halted         = halted_r;
  assign cu.instr_valid = valid_r;
  assign cu.instr       = mem_instr_r[rd_ptr_r];
  assign cu.instr_pc    = mem_pc_r[rd_ptr_r];
endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch queue between the combinational program memory and the control unit. It walks sequential program addresses, buffers fetched 16-bit instruction words with their addresses in a small FIFO, and presents them to the control unit over a valid/ready handshake. A branch or jump redirect flushes the queue and restarts fetch at the target. Fetch stops at the all-ones halt address.

## Interface
- `PC_WIDTH`, 6: program address width; halt address is `(1<<PC_WIDTH)-1`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `pm_addr` out PC_WIDTH: program memory address; combinationally equals internal `fetch_pc`.
- `pm_data` in 16: program memory read data for `pm_addr`, same cycle (combinational ROM).
- `instr_valid` out 1: head entry present.
- `instr_ready` in 1: consumer accepts head this cycle.
- `instr` out 16: head instruction word.
- `instr_pc` out PC_WIDTH: address of head instruction.
- `redirect` in 1: flush queue and restart fetch.
- `redirect_pc` in PC_WIDTH: restart address, sampled when `redirect`=1.
- `halted` out 1: fetch at halt address and queue empty.
- `count` out clog2(DEPTH)+1: current occupancy.

## Operation
- State: `fetch_pc`, write pointer, read pointer, `count`, DEPTH×(16+PC_WIDTH) storage.
- Push condition per cycle: `redirect`=0 AND `fetch_pc`≠halt address AND (`count`<DEPTH OR pop this cycle). Push writes {`fetch_pc`, `pm_data`} at the write pointer; `fetch_pc` increments by 1.
- Pop: `instr_valid`=1 AND `instr_ready`=1 AND `redirect`=0; read pointer advances.
- Simultaneous push and pop: `count` unchanged; permitted at full (DEPTH) and at 1.
- Pointers wrap modulo DEPTH; `fetch_pc` never wraps because fetch stops at the halt address.
- `instr_valid` = (`count`≠0). `instr` and `instr_pc` are driven from storage at the read pointer (show-ahead). Their value is don't-care when `instr_valid`=0.
- Redirect, top priority: on the edge with `redirect`=1, `count`←0, both pointers←0, `fetch_pc`←`redirect_pc`. No push and no pop occur that cycle, even if `instr_ready`=1.
- Halt: when `fetch_pc` equals the halt address, pushes stop and `fetch_pc` holds. The queue continues draining. `halted`=1 once `count`=0. Only a redirect or reset leaves halt. A redirect whose target is the halt address enters halt directly.
- Handshake rule: `instr`/`instr_pc` remain stable while `instr_valid`=1 and `instr_ready`=0, unless `redirect` is asserted.

## Timing
- Reset (asynchronous, `reset`=0): `fetch_pc`=0, pointers=0, `count`=0, `instr_valid`=0, `halted`=0, `pm_addr`=0. Storage is not cleared; `instr`/`instr_pc` are don't-care.
- First push occurs at the first rising edge after `reset` deasserts. `instr_valid`=1 one cycle after reset release, with `instr_pc`=0.
- Fetch-to-visible latency is 1 cycle: a word pushed at edge N is at the head after edge N if the queue was empty.
- Redirect-to-valid latency is 2 edges: edge N flushes; edge N+1 pushes the target; `instr_valid`=1 after N+1.
- Sustained throughput is 1 instruction per cycle with `instr_ready` held high.
- `halted` and `count` are registered-state derived and glitch-free relative to the clock.

## Test plan
- Reset release with `instr_ready`=0, ROM[i]=0x1000+i: after 4 edges `count`=4, `instr_pc`=0, `instr`=0x1000, `pm_addr`=4. Queue holds at full, `fetch_pc` stays 4.
- Full queue, then `instr_ready`=1 continuously: `instr_pc` sequence 0,1,2,3,4,… one per cycle, `count` stays 4 (push and pop together).
- Redirect with `redirect_pc`=0x20 while `count`=3 and `instr_ready`=1: next cycle `count`=0, `instr_valid`=0, no pop counted. Following cycle `instr_pc`=0x20.
- Redirect to 0x3C with `instr_ready`=1: entries 0x3C, 0x3D, 0x3E delivered, 0x3F never pushed. `halted`=1 after 0x3E pops, `pm_addr` holds 0x3F.
- While halted, redirect to 0x05: `halted`=0 next cycle, `instr_pc`=0x05 valid one cycle later.
- Assert `reset`=0 mid-cycle with `count`=2: `count`, `instr_valid`, and `pm_addr` go to 0 immediately, without waiting for a clock edge. Normal refill resumes from address 0 after release.
